// File: rtl/seg_pkg.sv
// Shared types and constants for the product BCD conversion and 7-segment scan.
package seg_pkg;

   localparam int unsigned BIN_W      = 16;
   localparam int unsigned BCD_W      = 20;
   localparam int unsigned BCD_DIGITS = 5;
   localparam int unsigned DIGITS     = 8;
   localparam int unsigned ITER_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      LOAD
   } conv_state_e;

   // Active-high glyphs {dp,g,f,e,d,c,b,a}; entry n is BCD code n, codes 10..15 blank.
   localparam logic [15:0][7:0] GLYPH_TAB = {
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
      8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-and-adjust iteration per clock, 16 iterations.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   conv_state_e       state_q, state_d;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]  acc_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              busy_d;
   logic              done_d;
   logic [BCD_W-1:0]  adj;

   // Add 3 to every nibble that is 5 or more before the shift.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
      logic [BCD_W-1:0] r;
      r = a;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd     <= '0;
         iter_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd     <= acc_d;
         iter_q  <= iter_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = bcd;
      iter_d  = iter_q;
      busy_d  = busy;
      done_d  = 1'b0;
      adj     = add3(bcd);
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin;
               acc_d   = '0;
               iter_d  = '0;
               busy_d  = 1'b1;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            acc_d  = BCD_W'({adj, bin_q[BIN_W-1]});
            bin_d  = bin_q << 1;
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(BIN_W - 1)) begin
               done_d  = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/product_seg_scan.sv
// Converts the multiplier product to BCD and scans it onto an 8-digit 7-segment display.
module product_seg_scan
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          BLANK_LEADING  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  d_in,
   input  logic              d_valid,
   output logic              busy,
   output logic [BCD_W-1:0]  bcd_out,
   output logic [DIGITS-1:0] seg_position,
   output logic [7:0]        seg_data
);

   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = 3;
   localparam logic [7:0]  OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic                  conv_done;
   logic [BCD_W-1:0]      conv_acc;
   logic [PRE_W-1:0]      pre_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  slot_end;
   logic [BCD_DIGITS-1:0] nz_from;
   logic [3:0]            nib;
   logic                  show;
   logic [DIGITS-1:0]     pos_c;
   logic [7:0]            glyph_c;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (d_valid),
      .bin   (d_in),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_acc)
   );

   assign slot_end = (pre_q == PRE_W'(SCAN_DIV - 1));

   // Free-running prescaler, scan index and committed BCD value.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         idx_q   <= '0;
         bcd_out <= '0;
      end else begin
         pre_q <= slot_end ? '0 : pre_q + PRE_W'(1);
         if (slot_end) idx_q <= idx_q + IDX_W'(1);
         if (conv_done) bcd_out <= conv_acc;
      end
   end

   // nz_from[k] is set when any nibble from k up to the MSD is nonzero.
   always_comb begin
      nz_from = '0;
      nz_from[BCD_DIGITS-1] = |bcd_out[BCD_W-1 -: 4];
      for (int k = int'(BCD_DIGITS) - 2; k >= 0; k--) begin
         nz_from[k] = nz_from[k+1] | (|bcd_out[4*k +: 4]);
      end
   end

   always_comb begin
      nib   = '0;
      show  = 1'b0;
      pos_c = '0;
      pos_c[idx_q] = 1'b1;
      for (int k = 0; k < int'(BCD_DIGITS); k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib  = bcd_out[4*k +: 4];
            show = (k == 0) || !BLANK_LEADING || nz_from[k];
         end
      end
      glyph_c = show ? GLYPH_TAB[nib] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_position <= OFF;
         seg_data     <= OFF;
      end else begin
         seg_position <= SEG_ACTIVE_LOW ? ~pos_c : pos_c;
         seg_data     <= SEG_ACTIVE_LOW ? ~glyph_c : glyph_c;
      end
   end

endmodule

// File: tb/tb_product_seg_scan.sv
// Self-checking bench for product_seg_scan: vector table, corner sequences, random products.
module tb_product_seg_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a_din, b_din;
   logic        a_valid, b_valid;
   logic        a_busy, b_busy;
   logic [19:0] a_bcd, b_bcd;
   logic [7:0]  a_pos, b_pos, a_data, b_data;

   int n_cmp = 0;
   int n_bad = 0;
   int n_edge = 0;
   int va = 0;

   always #5 clk = ~clk;

   product_seg_scan #(.SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
      .clk(clk), .rst(rst), .d_in(a_din), .d_valid(a_valid), .busy(a_busy),
      .bcd_out(a_bcd), .seg_position(a_pos), .seg_data(a_data));

   product_seg_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_b (
      .clk(clk), .rst(rst), .d_in(b_din), .d_valid(b_valid), .busy(b_busy),
      .bcd_out(b_bcd), .seg_position(b_pos), .seg_data(b_data));

   // Edges since reset release; edge 1 is the first edge with rst low.
   always @(posedge clk) begin
      if (rst) n_edge <= 0;
      else     n_edge <= n_edge + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p *= 10;
      return p;
   endfunction

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r = '0;
      for (int k = 0; k < 5; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
      return r;
   endfunction

   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   // Expected active-low segment byte for digit position k of decimal value v.
   function automatic logic [7:0] exp_seg(input int v, input int k, input bit blank_lead);
      if (k >= 5) return 8'hFF;
      if (blank_lead && k > 0 && v < pow10(k)) return 8'hFF;
      return ~glyph((v / pow10(k)) % 10);
   endfunction

   function automatic logic [7:0] exp_pos(input int k);
      logic [7:0] one = 8'h01;
      return ~(one << k);
   endfunction

   task automatic check_scan_a(input int v);
      int k = ((n_edge - 1) / 2) % 8;
      chk($sformatf("a_pos slot%0d", k), a_pos, exp_pos(k));
      chk($sformatf("a_data slot%0d v=%0d", k, v), a_data, exp_seg(v, k, 1'b1));
   endtask

   task automatic check_scan_b(input int v);
      int k = (n_edge - 1) % 8;
      chk($sformatf("b_pos slot%0d", k), b_pos, exp_pos(k));
      chk($sformatf("b_data slot%0d v=%0d", k, v), b_data, exp_seg(v, k, 1'b0));
   endtask

   // Starts a conversion on dut_a; optionally injects a stray d_valid or a reset mid-run.
   task automatic convert(input logic [15:0] v, input int inj_at, input int rst_at,
                          output int busy_cycles);
      a_din   = v;
      a_valid = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      busy_cycles = 0;
      while (a_busy && busy_cycles < 40) begin
         busy_cycles++;
         if (busy_cycles == inj_at) begin
            a_din   = ~v;
            a_valid = 1'b1;
         end else begin
            a_valid = 1'b0;
         end
         if (busy_cycles == 10) chk("bcd_hold_mid_conv", a_bcd, to_bcd(va));
         if (busy_cycles == rst_at) rst = 1'b1;
         @(negedge clk);
         if (rst) begin
            chk("rst_abort busy", a_busy, 0);
            chk("rst_abort bcd", a_bcd, 0);
            chk("rst_abort pos", a_pos, 8'hFF);
            chk("rst_abort data", a_data, 8'hFF);
            rst = 1'b0;
            va  = 0;
            busy_cycles = -1;
            return;
         end
      end
      a_valid = 1'b0;
   endtask

   typedef struct {
      logic [15:0] din;
      logic [19:0] bcd;
      int          inj_at;
      int          rst_at;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int bc;
      int r;
      tbl[0] = '{16'd2451,  20'h02451, 0, 0};
      tbl[1] = '{16'd12720, 20'h12720, 0, 0};
      tbl[2] = '{16'hFFFF,  20'h65535, 0, 0};
      tbl[3] = '{16'd0,     20'h00000, 0, 0};
      tbl[4] = '{16'd1234,  20'h00000, 0, 8};
      tbl[5] = '{16'd10000, 20'h10000, 0, 0};
      tbl[6] = '{16'd7,     20'h00007, 0, 0};
      tbl[7] = '{16'd2451,  20'h02451, 5, 0};

      rst = 1'b1;
      a_din = '0; a_valid = 1'b0;
      b_din = '0; b_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset busy", a_busy, 0);
      chk("reset bcd", a_bcd, 0);
      chk("reset pos", a_pos, 8'hFF);
      chk("reset data", a_data, 8'hFF);
      rst = 1'b0;

      // Idle display of zero across all slots.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check_scan_a(0);
      end
      chk("idle busy", a_busy, 0);
      chk("idle bcd", a_bcd, 0);

      for (int t = 0; t < 8; t++) begin
         convert(tbl[t].din, tbl[t].inj_at, tbl[t].rst_at, bc);
         if (tbl[t].rst_at != 0) begin
            chk($sformatf("vec%0d aborted", t), bc, 32'hFFFF_FFFF);
            @(negedge clk);
            chk($sformatf("vec%0d bcd after rst", t), a_bcd, tbl[t].bcd);
            check_scan_a(0);
         end else begin
            chk($sformatf("vec%0d busy cycles", t), bc, 17);
            chk($sformatf("vec%0d bcd", t), a_bcd, tbl[t].bcd);
            va = int'(tbl[t].din);
            @(negedge clk);
            for (int i = 0; i < 16; i++) begin
               check_scan_a(va);
               @(negedge clk);
            end
         end
      end

      // Random products against the arithmetic model.
      for (int t = 0; t < 12; t++) begin
         r = int'($urandom_range(0, 65535));
         convert(16'(r), 0, 0, bc);
         chk($sformatf("rand%0d busy cycles", t), bc, 17);
         chk($sformatf("rand%0d bcd v=%0d", t, r), a_bcd, to_bcd(r));
         va = r;
         @(negedge clk);
         for (int i = 0; i < 16; i++) begin
            check_scan_a(va);
            @(negedge clk);
         end
      end

      // d_valid held high in idle restarts a capture on every idle edge.
      a_din = 16'd321;
      a_valid = 1'b1;
      for (int i = 0; i < 19; i++) @(negedge clk);
      chk("held_valid busy restart", a_busy, 1);
      chk("held_valid bcd", a_bcd, 20'h00321);
      a_valid = 1'b0;
      for (int i = 0; i < 20; i++) @(negedge clk);
      chk("held_valid settled", a_busy, 0);
      va = 321;

      // Free-run: one-hot position, slot length and wrap.
      for (int i = 0; i < 40; i++) begin
         chk("a onehot", 32'($countones(~a_pos)), 1);
         check_scan_a(va);
         @(negedge clk);
      end

      // No leading blanking and one-cycle slots on the second instance.
      b_din = 16'd7;
      b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      for (int i = 0; i < 20; i++) @(negedge clk);
      chk("b busy done", b_busy, 0);
      chk("b bcd", b_bcd, 20'h00007);
      for (int i = 0; i < 16; i++) begin
         chk("b onehot", 32'($countones(~b_pos)), 1);
         check_scan_b(7);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
